lcz80_reg_dbg: RTL
==================

# lcz80_reg_dbg

Debug save/restore controller for the Z80 register file (8 entries × 16 bits, split H/L byte lanes, 3-bit address on the write/read-A port). It sits between the CPU core and the register file's A port. It arbitrates that port between the core and a debug host. On a host command it stalls the core at an instruction boundary, then sequences a full dump (read all 8 pairs out as a stream) or load (write all 8 pairs from a stream).

## Interface
Parameters:
- none (entry count fixed at 8, word width fixed at 16)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_addra  in  3  core A-port address (pass-through when idle)
- core_dih / core_dil  in  8 / 8  core write data H/L
- core_weh / core_wel / core_cen  in  1 each  core write enables / clock enable
- core_idle  in  1  core is at an instruction boundary and may be held
- core_stall  out  1  core must hold all state while high
- rf_addra  out  3  register file A-port address
- rf_dih / rf_dil  out  8 / 8  register file write data
- rf_weh / rf_wel / rf_cen  out  1 each  register file write enables / clock enable
- rf_doah / rf_doal  in  8 / 8  register file A-port read data (combinational)
- cmd_valid  in  1  host command request
- cmd_op  in  1  0 = dump, 1 = load
- cmd_ready  out  1  controller accepts a command
- dout_valid / dout_ready  out / in  1 / 1  dump stream handshake
- dout_data  out  16  {H,L} of dumped entry
- dout_idx  out  3  entry index of dout_data
- din_valid / din_ready  in / out  1 / 1  load stream handshake
- din_data  in  16  {H,L} to write
- done  out  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, WAIT, DUMP, DRAIN, LOAD, DONE. Internal: op bit, idx[2:0].
- IDLE: cmd_ready=1, core_stall=0. rf_* = core_* (pure combinational pass-through). On cmd_valid&&cmd_ready: latch op, idx←0, go to WAIT.
- WAIT: core_stall=1. rf_weh/rf_wel/rf_cen forced 0. On core_idle=1 → DUMP (op=0) or LOAD (op=1).
- DUMP: rf_addra=idx, write enables 0. When !dout_valid || dout_ready: dout_data←{rf_doah,rf_doal}, dout_idx←idx, dout_valid←1. If idx==7 go to DRAIN, else idx←idx+1.
- DRAIN: on dout_valid&&dout_ready: dout_valid←0, go to DONE.
- LOAD: din_ready=1, rf_addra=idx, rf_dih/rf_dil=din_data[15:8]/[7:0]. On din_valid: rf_weh=rf_wel=rf_cen=1 that cycle. If idx==7 go to DONE, else idx←idx+1.
- DONE: done=1, core_stall=1, no writes → IDLE.
- dout_valid: once high, it stays high with dout_data/dout_idx stable until dout_ready is sampled high.
- idx never wraps: the state exits at 7.
- cmd_valid outside IDLE is ignored (cmd_ready=0). There is no abort except rst_n.
- core_* write enables are never forwarded outside IDLE. core_idle is sampled only in WAIT.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, idx=0, dout_valid=0, dout_data=0, dout_idx=0, done=0. Combinational outputs at reset: core_stall=0, cmd_ready=1, din_ready=0.
- Reset mid-sequence: immediate return to IDLE. The register file keeps any already-written entries, and no further writes occur.
- Accept at cycle T; core_stall is high from T+1.
- With core_idle=1 at T+1: first DUMP/LOAD cycle is T+2.
- Dump with dout_ready held 1: dout_valid is high T+3..T+10 (one entry per cycle). DRAIN handshake at T+10, done at T+11, IDLE and core_stall=0 at T+12.
- Load with din_valid held 1: writes at T+2..T+9, done at T+10, IDLE at T+11.
- Back-pressure or data gaps stretch the sequence cycle-for-cycle, with no loss or duplication.
- core_stall deasserts in the same cycle as the return to IDLE. The core may issue a write that cycle.

## Test plan
- Reset then idle: core_addra=3, core_weh=core_wel=core_cen=1, core_dih/dil=0x12/0x34 → rf_* mirror in the same cycle. Entry 3 reads 0x1234.
- Dump with preloaded entries k=0..7 holding 0x1100+k, dout_ready=1, core_idle=1 → 8 beats 0x1100..0x1107, dout_idx 0..7, done at T+11.
- Dump with dout_ready toggled 1,0,0,1,… → each beat held stable while stalled. Exactly 8 transfers in order, no repeats.
- Load of 0xA000+k, din_valid gapped every other cycle → 8 writes. A later dump returns 0xA000..0xA007, and no writes occur during gap cycles.
- core_idle held 0 for 5 cycles after accept → core_stall=1, no rf writes, core writes blocked. The sequence starts the cycle after core_idle rises. cmd_valid during the sequence is not accepted.
- rst_n asserted after the 4th load write → immediately IDLE with dout_valid=0. Entries 0–3 hold new values and entries 4–7 are unchanged.

Source files
------------

// File: rtl/lcz80_reg_dbg_if.sv
// Debug host handshake bundle for lcz80_reg_dbg: command, dump stream and load stream.
// The host drives the master side and the controller is the slave.
interface lcz80_reg_dbg_if;
  logic        cmd_valid;
  logic        cmd_op;
  logic        cmd_ready;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic [2:0]  dout_idx;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_data;
  logic        done;

  modport master (
    output cmd_valid, cmd_op, dout_ready, din_valid, din_data,
    input  cmd_ready, dout_valid, dout_data, dout_idx, din_ready, done
  );

  modport slave (
    input  cmd_valid, cmd_op, dout_ready, din_valid, din_data,
    output cmd_ready, dout_valid, dout_data, dout_idx, din_ready, done
  );
endinterface

// File: rtl/lcz80_reg_dbg.sv
// Arbitrates the Z80 register file A port between the core and a debug host,
// stalling the core at an instruction boundary to dump or load all 8 pairs.
module lcz80_reg_dbg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] core_addra,
  input  logic [7:0] core_dih,
  input  logic [7:0] core_dil,
  input  logic       core_weh,
  input  logic       core_wel,
  input  logic       core_cen,
  input  logic       core_idle,
  output logic       core_stall,
  output logic [2:0] rf_addra,
  output logic [7:0] rf_dih,
  output logic [7:0] rf_dil,
  output logic       rf_weh,
  output logic       rf_wel,
  output logic       rf_cen,
  input  logic [7:0] rf_doah,
  input  logic [7:0] rf_doal,
  lcz80_reg_dbg_if.slave dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DUMP, S_DRAIN, S_LOAD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [2:0]  idx_q, idx_d;
  logic        dout_valid_q, dout_valid_d;
  logic [15:0] dout_data_q, dout_data_d;
  logic [2:0]  dout_idx_q, dout_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      idx_q        <= 3'd0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= 16'd0;
      dout_idx_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_idx_q   <= dout_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_idx_d   = dout_idx_q;
    case (state_q)
      S_IDLE: begin
        if (dbg.cmd_valid) begin
          op_d    = dbg.cmd_op;
          idx_d   = 3'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_idle) state_d = op_q ? S_LOAD : S_DUMP;
      end
      S_DUMP: begin
        // A new beat may replace the held one in the same cycle it is taken.
        if (!dout_valid_q || dbg.dout_ready) begin
          dout_data_d  = {rf_doah, rf_doal};
          dout_idx_d   = idx_q;
          dout_valid_d = 1'b1;
          if (idx_q == 3'd7) state_d = S_DRAIN;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (dout_valid_q && dbg.dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = S_DONE;
        end
      end
      S_LOAD: begin
        if (dbg.din_valid) begin
          if (idx_q == 3'd7) state_d = S_DONE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_stall    = 1'b1;
    dbg.cmd_ready = 1'b0;
    dbg.din_ready = 1'b0;
    dbg.done      = 1'b0;
    rf_addra      = idx_q;
    rf_dih        = dbg.din_data[15:8];
    rf_dil        = dbg.din_data[7:0];
    rf_weh        = 1'b0;
    rf_wel        = 1'b0;
    rf_cen        = 1'b0;
    case (state_q)
      S_IDLE: begin
        core_stall    = 1'b0;
        dbg.cmd_ready = 1'b1;
        rf_addra      = core_addra;
        rf_dih        = core_dih;
        rf_dil        = core_dil;
        rf_weh        = core_weh;
        rf_wel        = core_wel;
        rf_cen        = core_cen;
      end
      S_LOAD: begin
        dbg.din_ready = 1'b1;
        rf_weh        = dbg.din_valid;
        rf_wel        = dbg.din_valid;
        rf_cen        = dbg.din_valid;
      end
      S_DONE:  dbg.done = 1'b1;
      default: ;
    endcase
  end

  assign dbg.dout_valid = dout_valid_q;
  assign dbg.dout_data  = dout_data_q;
  assign dbg.dout_idx   = dout_idx_q;

endmodule
